fb_arbiter: RTL and testbench

- Shares the single-port 512x8 synchronous-read framebuffer RAM between the neopixel display reader (read-only, highest priority) and a host/animation port (read/write, req/ack handshake).
- Double-buffers the frame in two banks of 2^FRAME_AW bytes each. The host always accesses the back bank. The display always reads the front bank.
- A host-requested bank swap takes effect only at a display frame start, so the display never shows a torn frame.

---
 rtl/fb_arbiter.sv | 112 +++++++++++
 tb/tb_fb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: display reader (priority) vs host req/ack port,
// with double-buffered banks swapped only at a display frame start.
module fb_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int FRAME_AW = 6
) (
  input  logic              clk_20M,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [7:0]        disp_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [FRAME_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  input  logic              host_swap,
  output logic              swap_done,
  output logic              front_bank,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [7:0]        disp_data_q, disp_data_d;
  logic [7:0]        host_rdata_q, host_rdata_d;
  logic              host_ack_q, host_ack_d;
  logic              host_rd_q, host_rd_d;
  logic              host_busy_q, host_busy_d;
  logic              fetch_q, fetch_d;
  logic              swap_pend_q, swap_pend_d;
  logic              swap_done_q, swap_done_d;
  logic              front_q, front_d;
  logic              prev_zero_q, prev_zero_d;

  logic disp_zero, fs, apply, front_nxt, disp_fetch, grant;

  always_comb begin
    disp_zero  = (disp_addr[FRAME_AW-1:0] == '0);
    fs         = disp_zero & ~prev_zero_q;
    apply      = fs & swap_pend_q;
    // the fetch issued on the frame-start cycle already sees the new front bank
    front_nxt  = front_q ^ apply;
    disp_fetch = (disp_addr != disp_addr_q);
    grant      = host_req & ~disp_fetch & ~host_busy_q;

    disp_addr_d  = disp_fetch ? disp_addr : disp_addr_q;
    fetch_d      = disp_fetch;
    disp_data_d  = fetch_q ? ram_rdata : disp_data_q;
    host_busy_d  = grant;
    host_ack_d   = grant;
    host_rd_d    = grant & ~host_we;
    host_rdata_d = (host_ack_q & host_rd_q) ? ram_rdata : host_rdata_q;
    prev_zero_d  = disp_zero;
    swap_pend_d  = apply ? 1'b0 : (swap_pend_q | host_swap);
    swap_done_d  = apply;
    front_d      = front_nxt;

    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (nrst) begin
      if (disp_fetch) begin
        ram_addr[FRAME_AW]       = front_nxt;
        ram_addr[FRAME_AW-1:0]   = disp_addr[FRAME_AW-1:0];
      end else if (grant) begin
        ram_addr[FRAME_AW]       = ~front_q;
        ram_addr[FRAME_AW-1:0]   = host_addr;
        ram_we                   = host_we;
        ram_wdata                = host_wdata;
      end
    end
  end

  always_ff @(posedge clk_20M) begin
    if (!nrst) begin
      disp_addr_q  <= '1;
      disp_data_q  <= '0;
      host_rdata_q <= '0;
      host_ack_q   <= 1'b0;
      host_rd_q    <= 1'b0;
      host_busy_q  <= 1'b0;
      fetch_q      <= 1'b0;
      swap_pend_q  <= 1'b0;
      swap_done_q  <= 1'b0;
      front_q      <= 1'b0;
      prev_zero_q  <= 1'b1;
    end else begin
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
      host_rd_q    <= host_rd_d;
      host_busy_q  <= host_busy_d;
      fetch_q      <= fetch_d;
      swap_pend_q  <= swap_pend_d;
      swap_done_q  <= swap_done_d;
      front_q      <= front_d;
      prev_zero_q  <= prev_zero_d;
    end
  end

  // read data is taken straight from the RAM in the ack cycle, then held
  assign host_rdata = (host_ack_q & host_rd_q) ? ram_rdata : host_rdata_q;
  assign host_ack   = host_ack_q & nrst;
  assign disp_data  = disp_data_q;
  assign swap_done  = swap_done_q;
  assign front_bank = front_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: behavioural RAM, host/swap scoreboards
// checked by a forked monitor, inline checks for cycle-exact addresses.
module tb_fb_arbiter;
  logic       clk_20M = 1'b0;
  logic       nrst;
  logic [8:0] disp_addr;
  logic [7:0] disp_data;
  logic       host_req, host_we;
  logic [5:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       host_swap, swap_done, front_bank;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata, ram_rdata;

  typedef struct {
    logic       is_rd;
    logic [8:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t hq[$];
  logic sq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [8:0] first_addr;
  logic [7:0] mem [512];
  logic init_done;

  always #25 clk_20M = ~clk_20M;

  fb_arbiter #(.ADDR_W(9), .FRAME_AW(6)) dut (
    .clk_20M(clk_20M), .nrst(nrst), .disp_addr(disp_addr), .disp_data(disp_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_swap(host_swap), .swap_done(swap_done), .front_bank(front_bank),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] init_val(input int i);
    case (i)
      0:       return 8'h22;
      1:       return 8'h33;
      9:       return 8'h99;
      64:      return 8'h11;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk_20M) begin
    if (!init_done) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_20M); #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_20M);
      if (host_ack) begin
        if (hq.size() == 0) chk("host_ack_unexpected", 1, 0);
        else begin
          e = hq.pop_front();
          if (e.is_rd) chk("host_rdata", host_rdata, e.data);
          else         chk("host_wr_mem", mem[e.addr], e.data);
        end
      end
      if (swap_done) begin
        if (sq.size() == 0) chk("swap_done_unexpected", 1, 0);
        else chk("swap_front", front_bank, sq.pop_front());
      end
    end
  endtask

  // issue one host access at the current cycle; lat = cycles from req to ack
  task automatic host_xfer(input logic we, input logic [5:0] a, input logic [7:0] wd,
                           input logic [7:0] rd, input int lat, input logic [8:0] ra);
    int n;
    logic [8:0] ga;
    logic gwe;
    exp_t e;
    e.is_rd = !we; e.addr = ra; e.data = we ? wd : rd;
    hq.push_back(e);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    n = 0; ga = '0; gwe = 1'b0;
    @(negedge clk_20M);
    first_addr = ram_addr;
    while (!host_ack && n < 8) begin
      ga = ram_addr; gwe = ram_we;
      cyc(); n++;
      @(negedge clk_20M);
    end
    chk("host_latency", n, lat);
    chk("grant_addr", ga, ra);
    chk("grant_we", gwe, we);
    cyc();
    host_req = 1'b0;
  endtask

  initial begin
    fork monitor(); join_none
    nrst = 1'b0; init_done = 1'b0; disp_addr = '0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; host_swap = 1'b0;
    cyc(); init_done = 1'b1;
    repeat (2) cyc();
    @(negedge clk_20M);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_front", front_bank, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_wdata", ram_wdata, 0);

    // first cycle after release: forced fetch of address 0
    cyc(); nrst = 1'b1;
    @(negedge clk_20M);
    chk("first_fetch_addr", ram_addr, 9'h000);
    chk("first_fetch_we", ram_we, 0);
    cyc();
    host_xfer(1'b1, 6'd5, 8'hA5, 8'h00, 1, 9'h045);
    chk("disp_data_after_rst", disp_data, 8'h22);
    chk("front_after_rst", front_bank, 0);
    host_xfer(1'b0, 6'd5, 8'h00, 8'hA5, 1, 9'h045);

    // display fetch collides with host request
    disp_addr = 9'd1;
    host_xfer(1'b1, 6'd6, 8'h5A, 8'h00, 2, 9'h046);
    chk("collide_fetch_addr", first_addr, 9'h001);
    chk("collide_disp_data", disp_data, 8'h33);
    host_xfer(1'b0, 6'd6, 8'h00, 8'h5A, 1, 9'h046);

    // two swap requests, one frame start: single toggle
    host_swap = 1'b1; cyc(); host_swap = 1'b0; cyc();
    host_swap = 1'b1; cyc(); host_swap = 1'b0;
    for (int a = 2; a < 48; a++) begin
      disp_addr = 9'(a); cyc(); cyc();
    end
    disp_addr = 9'd0; sq.push_back(1'b1);
    @(negedge clk_20M);
    chk("fs_fetch_addr", ram_addr, 9'h040);
    chk("fs_front_old", front_bank, 0);
    cyc(); @(negedge clk_20M);
    chk("swap_front_new", front_bank, 1);
    cyc(); @(negedge clk_20M);
    chk("swap_disp_data", disp_data, 8'h11);
    repeat (3) cyc();

    // swap requested on the frame-start cycle itself is deferred
    disp_addr = 9'd3; cyc(); cyc();
    disp_addr = 9'd0; host_swap = 1'b1; cyc(); host_swap = 1'b0; cyc();
    @(negedge clk_20M);
    chk("defer_front", front_bank, 1);
    cyc();
    disp_addr = 9'd7; cyc(); cyc();
    disp_addr = 9'd0; sq.push_back(1'b0);
    @(negedge clk_20M);
    chk("defer_fs_addr", ram_addr, 9'h000);
    cyc(); cyc(); @(negedge clk_20M);
    chk("defer_disp_data", disp_data, 8'h22);
    chk("defer_front_after", front_bank, 0);

    // bring front to 1, leave a swap pending, then reset mid-transaction
    cyc();
    host_swap = 1'b1; cyc(); host_swap = 1'b0;
    disp_addr = 9'd9; cyc(); cyc();
    disp_addr = 9'd0; sq.push_back(1'b1);
    repeat (3) cyc();
    host_swap = 1'b1; cyc(); host_swap = 1'b0;
    disp_addr = 9'd9; cyc(); cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd5;
    @(negedge clk_20M);
    chk("rst_grant_addr", ram_addr, 9'h005);
    cyc(); nrst = 1'b0; host_req = 1'b0;
    @(negedge clk_20M);
    chk("rst_no_ack", host_ack, 0);
    cyc(); @(negedge clk_20M);
    chk("rst2_front", front_bank, 0);
    chk("rst2_disp_data", disp_data, 0);
    chk("rst2_ram_addr", ram_addr, 0);
    cyc(); nrst = 1'b1;
    @(negedge clk_20M);
    chk("post_rst_fetch", ram_addr, 9'h009);
    cyc(); cyc(); @(negedge clk_20M);
    chk("post_rst_disp_data", disp_data, 8'h99);
    // pending swap was cleared by reset: this frame start must not toggle
    disp_addr = 9'd0; cyc(); cyc();
    @(negedge clk_20M);
    chk("post_rst_front", front_bank, 0);
    repeat (3) cyc();

    chk("host_queue_empty", hq.size(), 0);
    chk("swap_queue_empty", sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
